// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions used by the host transmitter and the scan-code
// receiver: transmitter state encoding, frame edge constants and the
// odd-parity helper.
package ps2_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INHIBIT,
    ST_RTS,
    ST_SHIFT,
    ST_ACK,
    ST_RELEASE
  } tx_state_t;

  // Device clock falling-edge numbering within a host-to-device frame.
  localparam logic [3:0] DATA_BITS = 4'd8;   // edges 1..8 carry data, LSB first
  localparam logic [3:0] STOP_EDGE = 4'd10;  // data line released (stop = 1)
  localparam logic [3:0] ACK_EDGE  = 4'd11;  // device pulls data low to ACK

  // Odd parity: the parity bit makes the total count of ones odd.
  function automatic logic odd_parity(input logic [7:0] d);
    return ~^d;
  endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// PS/2 line conditioning: 2-flop synchronizers for ps2Clk and ps2Data plus a
// stability filter on ps2Clk.
//   clk, reset  : system clock, synchronous active-high reset
//   clkIn       : raw ps2Clk pin level
//   dataIn      : raw ps2Data pin level
//   clkLevel    : filtered ps2Clk level
//   fall        : one-cycle strobe on a filtered 1->0 transition of ps2Clk
//   dataLevel   : synchronized ps2Data level
module ps2_line_filter #(
  parameter int filterCycles = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic clkIn,
  input  logic dataIn,
  output logic clkLevel,
  output logic fall,
  output logic dataLevel
);

  localparam int CW = $clog2(filterCycles + 1);
  localparam logic [CW-1:0] STABLE_LAST = CW'(filterCycles - 1);

  logic [1:0]    clkSync;
  logic [1:0]    dataSync;
  logic [CW-1:0] stable;

  // Idle PS/2 lines are high, so everything resets to 1 to avoid a bogus
  // edge right after reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      clkSync  <= 2'b11;
      dataSync <= 2'b11;
      stable   <= '0;
      clkLevel <= 1'b1;
      fall     <= 1'b0;
    end else begin
      clkSync  <= {clkSync[0], clkIn};
      dataSync <= {dataSync[0], dataIn};
      fall     <= 1'b0;
      // Count consecutive samples that disagree with the accepted level; any
      // agreeing sample restarts the count, so short glitches are dropped.
      if (clkSync[1] == clkLevel) begin
        stable <= '0;
      end else if (stable == STABLE_LAST) begin
        stable   <= '0;
        clkLevel <= clkSync[1];
        fall     <= ~clkSync[1];
      end else begin
        stable <= stable + CW'(1);
      end
    end
  end

  assign dataLevel = dataSync[1];

endmodule

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter. Performs request-to-send, shifts one byte,
// odd parity and stop bit on device clock falling edges, and checks the
// device line-ACK.
//   clk, reset    : system clock, synchronous active-high reset
//   data/dataLoad : byte and one-cycle load request (taken only when ready)
//   ps2ClkIn      : raw ps2Clk pin;  ps2DataIn: raw ps2Data pin
//   ps2ClkDrive   : 1 pulls ps2Clk low; ps2DataDrive: 1 pulls ps2Data low
//   ready/busy    : idle / transaction in flight (busy gates the receiver)
//   done, ackOk   : one-cycle end pulse, ACK result valid with done
//   error         : sticky timeout / missing-ACK flag, cleared on next load
module ps2_host_tx #(
  parameter int counterBits   = 16,
  parameter int inhibitCycles = 1600,
  parameter int timeoutCycles = 40000,
  parameter int filterCycles  = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] data,
  input  logic       dataLoad,
  input  logic       ps2ClkIn,
  input  logic       ps2DataIn,
  output logic       ps2ClkDrive,
  output logic       ps2DataDrive,
  output logic       ready,
  output logic       busy,
  output logic       done,
  output logic       ackOk,
  output logic       error
);

  import ps2_pkg::*;

  localparam logic [counterBits-1:0] INH_LAST = counterBits'(inhibitCycles - 1);
  localparam logic [counterBits-1:0] TO_LAST  = counterBits'(timeoutCycles - 1);

  tx_state_t state, nextState;

  logic                   clkLevel, fall, dataLevel;
  logic [7:0]             txByte;
  logic [counterBits-1:0] cnt;
  logic [3:0]             edgeCnt;
  logic                   dataBit;   // drive level for the current data slot
  logic                   ackSeen;

  logic waiting, lineIdle, timeout, progress, finishOk, abort;

  ps2_line_filter #(.filterCycles(filterCycles)) u_filter (
    .clk       (clk),
    .reset     (reset),
    .clkIn     (ps2ClkIn),
    .dataIn    (ps2DataIn),
    .clkLevel  (clkLevel),
    .fall      (fall),
    .dataLevel (dataLevel)
  );

  // States that depend on the device and are therefore guarded by timeout.
  assign waiting  = (state == ST_RTS) || (state == ST_SHIFT) ||
                    (state == ST_ACK) || (state == ST_RELEASE);
  assign lineIdle = clkLevel & dataLevel;
  assign timeout  = (cnt == TO_LAST);
  // Activity that wins over a coincident timeout in the current state.
  assign progress = (state == ST_RELEASE) ? lineIdle : fall;
  assign finishOk = (state == ST_RELEASE) && lineIdle;
  assign abort    = waiting && timeout && !progress;

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= nextState;
  end

  // Next-state logic
  always_comb begin
    nextState = state;
    case (state)
      ST_IDLE:    if (dataLoad) nextState = ST_INHIBIT;
      ST_INHIBIT: if (cnt == INH_LAST) nextState = ST_RTS;
      ST_RTS:     if (fall) nextState = ST_SHIFT;
      ST_SHIFT:   if (fall && edgeCnt == STOP_EDGE - 4'd1) nextState = ST_ACK;
      ST_ACK:     if (fall) nextState = ST_RELEASE;
      ST_RELEASE: if (lineIdle) nextState = ST_IDLE;
      default:    nextState = ST_IDLE;
    endcase
    if (abort) nextState = ST_IDLE;
  end

  // Outputs
  always_comb begin
    ready        = (state == ST_IDLE);
    busy         = (state != ST_IDLE);
    ps2ClkDrive  = (state == ST_INHIBIT);
    // RTS holds the start bit (data low) while the clock is released.
    ps2DataDrive = (state == ST_RTS) || ((state == ST_SHIFT) && dataBit);
    done         = finishOk || abort;
    ackOk        = finishOk && ackSeen;
  end

  // Datapath: capture, shared counter, edge counter, bit drive, ACK, error
  always_ff @(posedge clk) begin
    if (reset) begin
      txByte  <= '0;
      cnt     <= '0;
      edgeCnt <= '0;
      dataBit <= 1'b0;
      ackSeen <= 1'b0;
      error   <= 1'b0;
    end else begin
      // Falls while we hold the clock low in INHIBIT are our own doing and
      // must not stretch the inhibit time.
      if ((state != nextState) || (waiting && fall)) cnt <= '0;
      else if (cnt != '1)                            cnt <= cnt + counterBits'(1);

      if (state == ST_IDLE && dataLoad) begin
        txByte  <= data;
        error   <= 1'b0;
        ackSeen <= 1'b0;
      end

      if (fall) begin
        case (state)
          ST_RTS: begin
            edgeCnt <= 4'd1;
            dataBit <= ~txByte[0];
          end
          ST_SHIFT: begin
            edgeCnt <= edgeCnt + 4'd1;
            // edgeCnt is the previous edge k-1, i.e. the index of bit k-1.
            if (edgeCnt < DATA_BITS)       dataBit <= ~txByte[edgeCnt[2:0]];
            else if (edgeCnt == DATA_BITS) dataBit <= ~odd_parity(txByte);
            else                           dataBit <= 1'b0;
          end
          ST_ACK: begin
            edgeCnt <= ACK_EDGE;
            ackSeen <= ~dataLevel;
          end
          default: ;
        endcase
      end

      if (done && !ackOk) error <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
module tb_ps2_host_tx;

  localparam int INH  = 20;
  localparam int TO   = 200;
  localparam int HALF = 20;   // device clock half period in system cycles

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] data = 8'h00;
  logic       dataLoad = 1'b0;
  logic       devClk = 1'b1;
  logic       devData = 1'b1;
  logic       ps2ClkIn, ps2DataIn;
  logic       ps2ClkDrive, ps2DataDrive, ready, busy, done, ackOk, error;

  int nCmp = 0;
  int nBad = 0;

  // Monitor state
  int   doneCnt = 0;
  logic lastAck = 1'b0;
  logic rdyAfter = 1'b0;
  logic doneQ = 1'b0;

  always #5 clk = ~clk;

  // Open-drain wired-AND of device and host
  assign ps2ClkIn  = devClk & ~ps2ClkDrive;
  assign ps2DataIn = devData & ~ps2DataDrive;

  ps2_host_tx #(
    .counterBits(16), .inhibitCycles(INH), .timeoutCycles(TO), .filterCycles(4)
  ) dut (
    .clk(clk), .reset(reset), .data(data), .dataLoad(dataLoad),
    .ps2ClkIn(ps2ClkIn), .ps2DataIn(ps2DataIn),
    .ps2ClkDrive(ps2ClkDrive), .ps2DataDrive(ps2DataDrive),
    .ready(ready), .busy(busy), .done(done), .ackOk(ackOk), .error(error)
  );

  always @(negedge clk) begin
    if (doneQ) rdyAfter = ready;
    if (done) begin
      doneCnt = doneCnt + 1;
      lastAck = ackOk;
    end
    doneQ = done;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic load_byte(input logic [7:0] b);
    data = b;
    dataLoad = 1'b1;
    tick(1);
    dataLoad = 1'b0;
  endtask

  // Ends in the first RTS cycle.
  task automatic start_tx(input logic [7:0] b);
    load_byte(b);
    tick(INH);
  endtask

  // Device: 11 clock pulses, recording the host data drive at the end of each
  // low phase. Optionally ACKs and injects a stray load at one edge.
  task automatic dev_frame(input logic giveAck, input int injectEdge,
                           output logic [11:1] obs);
    tick(10);
    for (int k = 1; k <= 11; k++) begin
      if (k == 11) devData = giveAck ? 1'b0 : 1'b1;
      devClk = 1'b0;
      if (k == injectEdge) begin
        tick(8);
        data = 8'h55;
        dataLoad = 1'b1;
        tick(1);
        dataLoad = 1'b0;
        tick(HALF - 9);
      end else begin
        tick(HALF);
      end
      obs[k] = ps2DataDrive;
      devClk = 1'b1;
      tick(HALF);
    end
    devData = 1'b1;
  endtask

  task automatic wait_done(input int d0);
    for (int i = 0; i < 200 && doneCnt == d0; i++) tick(1);
    tick(2);
  endtask

  task automatic test_reset();
    tick(3);
    reset = 1'b0;
    nCmp++; if (ps2ClkDrive !== 1'b0)  begin nBad++; $display("FAIL reset_clkDrive: got %b want 0", ps2ClkDrive); end
    nCmp++; if (ps2DataDrive !== 1'b0) begin nBad++; $display("FAIL reset_dataDrive: got %b want 0", ps2DataDrive); end
    nCmp++; if (ready !== 1'b1)        begin nBad++; $display("FAIL reset_ready: got %b want 1", ready); end
    nCmp++; if (busy !== 1'b0)         begin nBad++; $display("FAIL reset_busy: got %b want 0", busy); end
    nCmp++; if (done !== 1'b0)         begin nBad++; $display("FAIL reset_done: got %b want 0", done); end
    nCmp++; if (ackOk !== 1'b0)        begin nBad++; $display("FAIL reset_ackOk: got %b want 0", ackOk); end
    nCmp++; if (error !== 1'b0)        begin nBad++; $display("FAIL reset_error: got %b want 0", error); end
    tick(10);
  endtask

  task automatic test_send_ed();
    logic [11:1] obs, exp;
    int d0;
    exp = 11'h012;   // ~0xED on edges 1-8, parity 1 -> released, stop, ACK
    d0 = doneCnt;
    rdyAfter = 1'b0;
    load_byte(8'hED);
    nCmp++; if (ps2ClkDrive !== 1'b1) begin nBad++; $display("FAIL ed_inhibit_clk: got %b want 1", ps2ClkDrive); end
    tick(INH - 1);
    nCmp++; if ({ps2ClkDrive, ps2DataDrive} !== 2'b10) begin nBad++; $display("FAIL ed_inhibit_end: got %b want 10", {ps2ClkDrive, ps2DataDrive}); end
    tick(1);
    nCmp++; if ({ps2ClkDrive, ps2DataDrive} !== 2'b01) begin nBad++; $display("FAIL ed_rts: got %b want 01", {ps2ClkDrive, ps2DataDrive}); end
    dev_frame(1'b1, 0, obs);
    wait_done(d0);
    for (int k = 1; k <= 11; k++) begin
      nCmp++;
      if (obs[k] !== exp[k]) begin nBad++; $display("FAIL ed_edge%0d: got %b want %b", k, obs[k], exp[k]); end
    end
    nCmp++; if (doneCnt !== d0 + 1) begin nBad++; $display("FAIL ed_done_pulses: got %0d want %0d", doneCnt - d0, 1); end
    nCmp++; if (lastAck !== 1'b1)   begin nBad++; $display("FAIL ed_ackOk: got %b want 1", lastAck); end
    nCmp++; if (rdyAfter !== 1'b1)  begin nBad++; $display("FAIL ed_ready_after_done: got %b want 1", rdyAfter); end
    nCmp++; if (error !== 1'b0)     begin nBad++; $display("FAIL ed_error: got %b want 0", error); end
  endtask

  // 0x07 has parity 0 (data driven low on edge 9), then a load on the very
  // first ready cycle starts 0xED.
  task automatic test_parity0_back_to_back();
    logic [11:1] obs;
    int d0;
    start_tx(8'h07);
    dev_frame(1'b1, 0, obs);
    nCmp++; if (obs !== 11'h1F8) begin nBad++; $display("FAIL p0_bits: got %h want 1f8", obs); end
    for (int i = 0; i < 200; i++) begin
      if (done) break;
      tick(1);
    end
    nCmp++; if (done !== 1'b1)  begin nBad++; $display("FAIL p0_done: got %b want 1", done); end
    nCmp++; if (ackOk !== 1'b1) begin nBad++; $display("FAIL p0_ackOk: got %b want 1", ackOk); end
    tick(1);
    nCmp++; if (ready !== 1'b1) begin nBad++; $display("FAIL b2b_ready: got %b want 1", ready); end
    d0 = doneCnt;
    load_byte(8'hED);
    nCmp++; if ({busy, ps2ClkDrive} !== 2'b11) begin nBad++; $display("FAIL b2b_accept: got %b want 11", {busy, ps2ClkDrive}); end
    tick(INH);
    dev_frame(1'b1, 0, obs);
    wait_done(d0);
    nCmp++; if (obs !== 11'h012)  begin nBad++; $display("FAIL b2b_bits: got %h want 012", obs); end
    nCmp++; if (lastAck !== 1'b1) begin nBad++; $display("FAIL b2b_ackOk: got %b want 1", lastAck); end
  endtask

  task automatic test_no_ack();
    logic [11:1] obs;
    int d0;
    d0 = doneCnt;
    rdyAfter = 1'b0;
    start_tx(8'hFF);
    dev_frame(1'b0, 0, obs);
    wait_done(d0);
    nCmp++; if (obs !== 11'h000)    begin nBad++; $display("FAIL noack_bits: got %h want 000", obs); end
    nCmp++; if (doneCnt !== d0 + 1) begin nBad++; $display("FAIL noack_done_pulses: got %0d want 1", doneCnt - d0); end
    nCmp++; if (lastAck !== 1'b0)   begin nBad++; $display("FAIL noack_ackOk: got %b want 0", lastAck); end
    nCmp++; if (error !== 1'b1)     begin nBad++; $display("FAIL noack_error: got %b want 1", error); end
    nCmp++; if (rdyAfter !== 1'b1)  begin nBad++; $display("FAIL noack_ready: got %b want 1", rdyAfter); end
    load_byte(8'h00);
    nCmp++; if (error !== 1'b0) begin nBad++; $display("FAIL noack_error_clear: got %b want 0", error); end
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    tick(10);
  endtask

  task automatic test_timeout();
    int d0;
    d0 = doneCnt;
    start_tx(8'hF4);
    tick(TO - 2);
    nCmp++; if (done !== 1'b0) begin nBad++; $display("FAIL to_early: got done %b want 0", done); end
    tick(1);
    nCmp++; if ({done, ackOk} !== 2'b10) begin nBad++; $display("FAIL to_done: got %b want 10", {done, ackOk}); end
    tick(1);
    nCmp++; if ({ps2ClkDrive, ps2DataDrive} !== 2'b00) begin nBad++; $display("FAIL to_release: got %b want 00", {ps2ClkDrive, ps2DataDrive}); end
    nCmp++; if ({ready, error, done} !== 3'b110) begin nBad++; $display("FAIL to_status: got %b want 110", {ready, error, done}); end
    nCmp++; if (doneCnt !== d0 + 1) begin nBad++; $display("FAIL to_done_pulses: got %0d want 1", doneCnt - d0); end
    tick(5);
  endtask

  task automatic test_ignore_load();
    logic [11:1] obs;
    int d0;
    d0 = doneCnt;
    start_tx(8'hED);
    dev_frame(1'b1, 4, obs);
    wait_done(d0);
    nCmp++; if (obs !== 11'h012)    begin nBad++; $display("FAIL ign_bits: got %h want 012", obs); end
    nCmp++; if (doneCnt !== d0 + 1) begin nBad++; $display("FAIL ign_done_pulses: got %0d want 1", doneCnt - d0); end
    nCmp++; if (lastAck !== 1'b1)   begin nBad++; $display("FAIL ign_ackOk: got %b want 1", lastAck); end
    nCmp++; if (busy !== 1'b0)      begin nBad++; $display("FAIL ign_idle: got busy %b want 0", busy); end
  endtask

  task automatic test_reset_mid();
    int d0;
    start_tx(8'hED);
    tick(10);
    for (int k = 1; k <= 5; k++) begin
      devClk = 1'b0;
      tick(HALF);
      if (k < 5) begin
        devClk = 1'b1;
        tick(HALF);
      end
    end
    // Edge 5 carries bit 4 of 0xED (0), so data is pulled low.
    nCmp++; if (ps2DataDrive !== 1'b1) begin nBad++; $display("FAIL rm_edge5: got %b want 1", ps2DataDrive); end
    d0 = doneCnt;
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    nCmp++; if ({ps2ClkDrive, ps2DataDrive} !== 2'b00) begin nBad++; $display("FAIL rm_release: got %b want 00", {ps2ClkDrive, ps2DataDrive}); end
    nCmp++; if ({ready, busy} !== 2'b10) begin nBad++; $display("FAIL rm_ready: got %b want 10", {ready, busy}); end
    devClk = 1'b1;
    tick(20);
    nCmp++; if (doneCnt !== d0) begin nBad++; $display("FAIL rm_no_done: got %0d pulses want 0", doneCnt - d0); end
  endtask

  task automatic test_glitch();
    logic [11:1] obs;
    int d0;
    d0 = doneCnt;
    start_tx(8'h3C);
    tick(10);
    devClk = 1'b0;
    tick(2);
    devClk = 1'b1;
    tick(12);
    nCmp++; if ({busy, ps2DataDrive} !== 2'b11) begin nBad++; $display("FAIL gl_still_rts: got %b want 11", {busy, ps2DataDrive}); end
    dev_frame(1'b1, 0, obs);
    wait_done(d0);
    nCmp++; if (obs !== 11'h0C3)  begin nBad++; $display("FAIL gl_bits: got %h want 0c3", obs); end
    nCmp++; if (lastAck !== 1'b1) begin nBad++; $display("FAIL gl_ackOk: got %b want 1", lastAck); end
  endtask

  initial begin
    test_reset();
    test_send_ed();
    test_parity0_back_to_back();
    test_no_ack();
    test_timeout();
    test_ignore_load();
    test_reset_mid();
    test_glitch();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
    $finish;
  end

endmodule

// File: doc/ps2_host_tx.md
# ps2_host_tx

Host-to-device PS/2 transmitter: sends one command byte (e.g. 0xED set-LEDs, 0xFF reset) from the FPGA to the keyboard over the same open-drain ps2Clk/ps2Data lines the scan-code receiver listens on. It performs the PS/2 request-to-send sequence, shifts the byte, parity and stop bit on device-generated clock edges, and checks the device's line-ACK. It sits beside the PS/2 receiver/decoder. Its `busy` output gates that receiver so it ignores the line while a command is in flight.

## Interface
- `counterBits`, 16: width of the shared cycle counter; must hold `inhibitCycles` and `timeoutCycles`.
- `inhibitCycles`, 1600: cycles ps2Clk is held low before request-to-send (≥100 µs).
- `timeoutCycles`, 40000: max cycles between consecutive device clock falling edges, and for final line release.
- `filterCycles`, 4: consecutive identical synchronized samples required to accept a ps2Clk level change.

Ports:
- `clk` in 1: system clock.
- `reset` in 1: synchronous, active-high reset.
- `data` in 8: byte to send; captured on accepted load.
- `dataLoad` in 1: one-cycle request; accepted only when `ready`=1, ignored otherwise.
- `ps2ClkIn` in 1: raw ps2Clk pin level (asynchronous).
- `ps2DataIn` in 1: raw ps2Data pin level (asynchronous).
- `ps2ClkDrive` out 1: 1 = pull ps2Clk low, 0 = release (open drain).
- `ps2DataDrive` out 1: 1 = pull ps2Data low, 0 = release.
- `ready` out 1: idle, can accept `dataLoad`.
- `busy` out 1: transaction in progress (= !ready).
- `done` out 1: one-cycle pulse at transaction end (success or failure).
- `ackOk` out 1: valid with `done`; 1 = device ACKed.
- `error` out 1: sticky; set on timeout or missing ACK, cleared by next accepted `dataLoad` or reset.

## Operation
- Inputs pass a 2-flop synchronizer. ps2Clk then passes a `filterCycles` stability filter. A falling edge (`fall`) is a filtered 1→0 transition, one cycle wide.
- Odd parity: parity bit = ~^data.
- States:
  - IDLE: `ready`=1, both drives 0. An accepted load captures `data`, clears `error`, zeroes the counter, and goes to INHIBIT.
  - INHIBIT: `ps2ClkDrive`=1. After `inhibitCycles` cycles, assert `ps2DataDrive`=1 (start bit) and go to RTS.
  - RTS: release `ps2ClkDrive` in the same cycle as entry. Data stays low. Wait for `fall`, then go to SHIFT with edge count = 1.
  - SHIFT: on falling edges 1–8, set `ps2DataDrive` = ~bit[k-1] (LSB first). Edge 9 drives ~parity. Edge 10 releases data (stop bit = 1). Go to ACK.
  - ACK: on the next `fall`, sample synchronized ps2Data; 0 = ACK. Go to RELEASE.
  - RELEASE: wait until filtered ps2Clk=1 and synchronized ps2Data=1. Then pulse `done`, set `ackOk` from the sampled ACK, set `error` if no ACK, and return to IDLE.
- Timeout: the counter resets on each `fall` and on each state entry. In RTS, SHIFT, ACK or RELEASE, reaching `timeoutCycles` releases both lines, pulses `done` with `ackOk`=0, sets `error`, and returns to IDLE.
- A `dataLoad` while busy is dropped; the captured byte is never altered mid-transaction.

## Timing
- Reset values: `ps2ClkDrive`=0, `ps2DataDrive`=0, `ready`=1, `busy`=0, `done`=0, `ackOk`=0, `error`=0. Reset mid-transaction releases both lines on the next edge of `clk`, and the state returns to IDLE.
- `dataLoad` cycle N: `ps2ClkDrive`=1 from N+1. `ps2DataDrive`=1 at N+1+`inhibitCycles`. The same cycle releases the clock.
- Data drive updates in the cycle after the `fall` strobe, i.e. within sync (2) + filter (`filterCycles`) + 1 cycles of the pin edge. This is well inside the device's clock-low half-period.
- `done` is exactly one cycle. `ready` rises in the cycle after `done`.
- Minimum gap: a new `dataLoad` is accepted the first cycle `ready`=1.

## Structure
- Shared package `ps2_pkg`: state enum, PS/2 frame constants (data bits = 8, stop edge = 10, ACK edge = 11), odd-parity function. The receiver uses the same package.
- One sub-module, `ps2_line_filter`: 2-flop synchronizer plus stability filter. It outputs the filtered level and a one-cycle `fall` strobe, and is reusable by the receiver.

## Test plan
- Send 0xED with a device model ACKing: data line low on edges 1–8 as ~{1,0,1,1,0,1,1,1}; parity drive at edge 9 releases (parity = 1); released at edge 10. Require `done`=1, `ackOk`=1, `error`=0.
- Send 0x07: parity bit 0, so `ps2DataDrive`=1 after edge 9. ACK given → `ackOk`=1.
- Device model omits ACK (data high at edge 11) for 0xFF → `done`, `ackOk`=0, `error`=1. The next load clears `error`.
- Device never clocks after RTS → after `timeoutCycles` both drives 0, `done` pulse, `error`=1, `ready`=1.
- `dataLoad`=1 with 0x55 during SHIFT of 0xED → ignored; the transmitted bits stay 0xED.
- Assert `reset` at edge 5 → both drives 0 on the next cycle, `ready`=1, no `done` pulse. Inject a 2-cycle ps2Clk glitch at `filterCycles`=4 → no edge counted.
